cache_mem_buffer: RTL and testbench

- Word-serialising buffer between the fully-associative cache controller's memory-side port and the external memory interface.
- Accepts one request at a time from the cache: block or single word, read or write.
- Write data is staged in a write FIFO and drained to memory. Read data returned by memory is staged in a read FIFO and popped by the cache.
- Drives the ready_req/ready_write/ready_read handshake that the cache controller consumes.

---
 rtl/cache_mem_buffer.sv | 178 +++++++++++++++++
 tb/tb_cache_mem_buffer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_buffer.sv
// Word-serialising buffer between the cache memory-side port and external memory.
// One request at a time; writes are staged then drained, reads are staged then popped.
module cache_mem_buffer #(
    parameter int unsigned BW_ADDR  = 24,
    parameter int unsigned BW_BLOCK = 2
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               req_i,
    input  logic               req_block_i,
    input  logic               rw_i,
    input  logic [BW_ADDR-1:0] add_i,
    input  logic               write_i,
    input  logic [31:0]        data_i,
    input  logic               read_i,
    output logic               ready_req_o,
    output logic               ready_write_o,
    output logic               ready_read_o,
    output logic [31:0]        data_o,
    output logic               ext_req_o,
    output logic               ext_rw_o,
    output logic               ext_block_o,
    output logic [BW_ADDR-1:0] ext_add_o,
    output logic [31:0]        ext_data_o,
    input  logic               ext_ack_i,
    input  logic               ext_valid_i,
    input  logic [31:0]        ext_data_i
);

    localparam int unsigned BLOCK_WORDS = 2 ** BW_BLOCK;
    localparam int unsigned BW_CNT      = BW_BLOCK + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_FILL = 3'd1,
        WR_MEM  = 3'd2,
        RD_CMD  = 3'd3,
        RD_DATA = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                ready_req_q, ready_req_d;
    logic                block_q, block_d;
    logic [BW_CNT-1:0]   n_q, n_d;
    logic [BW_ADDR-1:0]  base_q, base_d;
    logic [BW_CNT-1:0]   cap_q, cap_d;
    logic [BW_CNT-1:0]   wcnt_q, wcnt_d;
    logic [BW_CNT-1:0]   rx_q, rx_d;
    logic [BW_CNT-1:0]   pop_q, pop_d;
    logic [31:0]         last_q, last_d;
    logic [31:0]         wmem_q [BLOCK_WORDS];
    logic [31:0]         wmem_d [BLOCK_WORDS];
    logic [31:0]         rmem_q [BLOCK_WORDS];
    logic [31:0]         rmem_d [BLOCK_WORDS];

    logic [BW_CNT-1:0]   rcount;
    logic [31:0]         rhead;
    logic                accept;
    logic                push;
    logic                pop;

    assign rcount = rx_q - pop_q;
    assign rhead  = rmem_q[pop_q[BW_BLOCK-1:0]];
    assign accept = req_i & ready_req_q;
    assign push   = (state_q == RD_DATA) && ext_valid_i && (rx_q < n_q);
    assign pop    = (state_q == RD_DATA) && read_i && (rcount != '0);

    // Next-state, counters and FIFO storage updates
    always_comb begin
        state_d = state_q;
        block_d = block_q;
        n_d     = n_q;
        base_d  = base_q;
        cap_d   = cap_q;
        wcnt_d  = wcnt_q;
        rx_d    = rx_q;
        pop_d   = pop_q;
        last_d  = last_q;
        wmem_d  = wmem_q;
        rmem_d  = rmem_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    block_d = req_block_i;
                    n_d     = req_block_i ? BW_CNT'(BLOCK_WORDS) : BW_CNT'(1);
                    base_d  = req_block_i ? (add_i & ~BW_ADDR'(BLOCK_WORDS - 1)) : add_i;
                    cap_d   = '0;
                    wcnt_d  = '0;
                    rx_d    = '0;
                    pop_d   = '0;
                    state_d = rw_i ? WR_FILL : RD_CMD;
                end
            end
            WR_FILL: begin
                if (write_i && (cap_q < n_q)) begin
                    wmem_d[cap_q[BW_BLOCK-1:0]] = data_i;
                    cap_d = cap_q + BW_CNT'(1);
                    if (cap_d == n_q) begin
                        state_d = WR_MEM;
                    end
                end
            end
            WR_MEM: begin
                if (ext_ack_i) begin
                    wcnt_d = wcnt_q + BW_CNT'(1);
                    if (wcnt_d == n_q) begin
                        state_d = IDLE;
                    end
                end
            end
            RD_CMD: begin
                if (ext_ack_i) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (push) begin
                    rmem_d[rx_q[BW_BLOCK-1:0]] = ext_data_i;
                    rx_d = rx_q + BW_CNT'(1);
                end
                if (pop) begin
                    last_d = rhead;
                    pop_d  = pop_q + BW_CNT'(1);
                    if (pop_d == n_q) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        ready_req_d = (state_d == IDLE);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            ready_req_q <= 1'b0;
            block_q     <= 1'b0;
            n_q         <= '0;
            base_q      <= '0;
            cap_q       <= '0;
            wcnt_q      <= '0;
            rx_q        <= '0;
            pop_q       <= '0;
            last_q      <= '0;
            wmem_q      <= '{default: '0};
            rmem_q      <= '{default: '0};
        end else begin
            state_q     <= state_d;
            ready_req_q <= ready_req_d;
            block_q     <= block_d;
            n_q         <= n_d;
            base_q      <= base_d;
            cap_q       <= cap_d;
            wcnt_q      <= wcnt_d;
            rx_q        <= rx_d;
            pop_q       <= pop_d;
            last_q      <= last_d;
            wmem_q      <= wmem_d;
            rmem_q      <= rmem_d;
        end
    end

    // Output decode from registered state only
    assign ready_req_o   = ready_req_q;
    assign ready_write_o = (state_q == WR_FILL) && (cap_q < n_q);
    assign ready_read_o  = (rcount != '0);
    assign data_o        = (rcount != '0) ? rhead : last_q;
    assign ext_req_o     = (state_q == WR_MEM) || (state_q == RD_CMD);
    assign ext_rw_o      = (state_q == WR_MEM);
    assign ext_block_o   = (state_q != IDLE) && block_q;
    assign ext_add_o     = (state_q == WR_MEM) ? (base_q + BW_ADDR'(wcnt_q)) :
                           (state_q == RD_CMD) ? base_q : '0;
    assign ext_data_o    = (state_q == WR_MEM) ? wmem_q[wcnt_q[BW_BLOCK-1:0]] : 32'h0;

endmodule

// File: tb/tb_cache_mem_buffer.sv
// Directed bench for cache_mem_buffer: writes, reads, stray strobes, mid-transfer reset.
module tb_cache_mem_buffer;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        req_i = 1'b0, req_block_i = 1'b0, rw_i = 1'b0;
    logic [23:0] add_i = '0;
    logic        write_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        read_i = 1'b0;
    logic        ready_req_o, ready_write_o, ready_read_o;
    logic [31:0] data_o;
    logic        ext_req_o, ext_rw_o, ext_block_o;
    logic [23:0] ext_add_o;
    logic [31:0] ext_data_o;
    logic        ext_ack_i = 1'b0, ext_valid_i = 1'b0;
    logic [31:0] ext_data_i = '0;

    int n_cmp = 0;
    int n_err = 0;

    cache_mem_buffer #(.BW_ADDR(24), .BW_BLOCK(2)) dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .req_i(req_i), .req_block_i(req_block_i), .rw_i(rw_i), .add_i(add_i),
        .write_i(write_i), .data_i(data_i), .read_i(read_i),
        .ready_req_o(ready_req_o), .ready_write_o(ready_write_o),
        .ready_read_o(ready_read_o), .data_o(data_o),
        .ext_req_o(ext_req_o), .ext_rw_o(ext_rw_o), .ext_block_o(ext_block_o),
        .ext_add_o(ext_add_o), .ext_data_o(ext_data_o),
        .ext_ack_i(ext_ack_i), .ext_valid_i(ext_valid_i), .ext_data_i(ext_data_i)
    );

    always #5 clock_i = ~clock_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock_i);
    endtask

    logic [31:0] wa [4] = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222, 32'hA333_3333};
    logic [31:0] rb [4] = '{32'hB000_0000, 32'hB111_1111, 32'hB222_2222, 32'hB333_3333};
    logic [31:0] rc [5] = '{32'hC000_0000, 32'hC111_1111, 32'hC222_2222, 32'hC333_3333, 32'hC444_4444};
    logic [31:0] wd [4] = '{32'hD000_0000, 32'hD111_1111, 32'hD222_2222, 32'hD333_3333};

    initial begin
        // reset state
        step(); step();
        check_eq("rst_ready_req", 32'(ready_req_o), 32'd0);
        check_eq("rst_ext_req", 32'(ext_req_o), 32'd0);
        check_eq("rst_ready_read", 32'(ready_read_o), 32'd0);
        check_eq("rst_data_o", data_o, 32'd0);
        reset_i = 1'b0;
        step();
        check_eq("post_rst_ready_req", 32'(ready_req_o), 32'd1);

        // block write at 0x123
        req_i = 1'b1; req_block_i = 1'b1; rw_i = 1'b1; add_i = 24'h000123;
        step();
        req_i = 1'b0;
        check_eq("wr_ready_req_low", 32'(ready_req_o), 32'd0);
        check_eq("wr_ready_write", 32'(ready_write_o), 32'd1);
        check_eq("wr_block", 32'(ext_block_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            write_i = 1'b1; data_i = wa[i];
            step();
        end
        write_i = 1'b0;
        check_eq("wr_ext_req_latency", 32'(ext_req_o), 32'd1);
        check_eq("wr_ready_write_off", 32'(ready_write_o), 32'd0);
        write_i = 1'b1; data_i = 32'hBAD0_BAD0;
        step();
        write_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("wr_add%0d", i), 32'(ext_add_o), 32'h120 + 32'(i));
            check_eq($sformatf("wr_data%0d", i), ext_data_o, wa[i]);
            check_eq($sformatf("wr_rw%0d", i), 32'(ext_rw_o), 32'd1);
            check_eq($sformatf("wr_rdyreq%0d", i), 32'(ready_req_o), 32'd0);
            ext_ack_i = 1'b1;
            step();
            ext_ack_i = 1'b0;
        end
        check_eq("wr_done_ready_req", 32'(ready_req_o), 32'd1);
        check_eq("wr_done_ext_req", 32'(ext_req_o), 32'd0);

        // single-word read at 0x45, stray ext_valid during RD_CMD
        req_i = 1'b1; req_block_i = 1'b0; rw_i = 1'b0; add_i = 24'h000045;
        step();
        req_i = 1'b0;
        check_eq("rd1_ext_req", 32'(ext_req_o), 32'd1);
        check_eq("rd1_rw", 32'(ext_rw_o), 32'd0);
        check_eq("rd1_block", 32'(ext_block_o), 32'd0);
        check_eq("rd1_add", 32'(ext_add_o), 32'h45);
        ext_valid_i = 1'b1; ext_data_i = 32'h1111_1111;
        step();
        ext_valid_i = 1'b0;
        step();
        check_eq("rd1_held", 32'(ext_req_o), 32'd1);
        ext_ack_i = 1'b1;
        step();
        ext_ack_i = 1'b0;
        check_eq("rd1_cmd_done", 32'(ext_req_o), 32'd0);
        check_eq("rd1_stray_dropped", 32'(ready_read_o), 32'd0);
        ext_valid_i = 1'b1; ext_data_i = 32'hDEAD_BEEF;
        step();
        ext_valid_i = 1'b0;
        check_eq("rd1_ready_read", 32'(ready_read_o), 32'd1);
        check_eq("rd1_data", data_o, 32'hDEAD_BEEF);
        read_i = 1'b1;
        step();
        check_eq("rd1_done_ready_req", 32'(ready_req_o), 32'd1);
        check_eq("rd1_empty", 32'(ready_read_o), 32'd0);
        step();
        read_i = 1'b0;
        check_eq("rd1_hold_data", data_o, 32'hDEAD_BEEF);

        // block read with simultaneous push/pop
        req_i = 1'b1; req_block_i = 1'b1; add_i = 24'h00007B;
        step();
        req_i = 1'b0;
        check_eq("rd3_add", 32'(ext_add_o), 32'h78);
        check_eq("rd3_block", 32'(ext_block_o), 32'd1);
        ext_ack_i = 1'b1;
        step();
        ext_ack_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            ext_valid_i = (c < 4);
            ext_data_i  = (c < 4) ? rb[c] : 32'h0;
            if (c > 0) begin
                check_eq($sformatf("rd3_rdy%0d", c), 32'(ready_read_o), 32'd1);
                check_eq($sformatf("rd3_data%0d", c), data_o, rb[c-1]);
                read_i = 1'b1;
            end else begin
                check_eq("rd3_rdy0", 32'(ready_read_o), 32'd0);
                read_i = 1'b0;
            end
            step();
        end
        read_i = 1'b0; ext_valid_i = 1'b0;
        check_eq("rd3_done_ready_req", 32'(ready_req_o), 32'd1);
        check_eq("rd3_empty", 32'(ready_read_o), 32'd0);

        // block read with 5th valid, write_i in RD_DATA, read_i on empty FIFO
        req_i = 1'b1; add_i = 24'h000200;
        step();
        req_i = 1'b0;
        ext_ack_i = 1'b1;
        step();
        ext_ack_i = 1'b0;
        read_i = 1'b1; write_i = 1'b1; data_i = 32'hBAD1_BAD1;
        step();
        read_i = 1'b0;
        check_eq("rd4_empty_pop", 32'(ready_read_o), 32'd0);
        check_eq("rd4_no_wr_ready", 32'(ready_write_o), 32'd0);
        check_eq("rd4_block", 32'(ext_block_o), 32'd1);
        for (int i = 0; i < 5; i++) begin
            ext_valid_i = 1'b1; ext_data_i = rc[i];
            step();
        end
        ext_valid_i = 1'b0; write_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("rd4_data%0d", i), data_o, rc[i]);
            read_i = 1'b1;
            step();
        end
        read_i = 1'b0;
        check_eq("rd4_done_ready_req", 32'(ready_req_o), 32'd1);
        check_eq("rd4_fifth_dropped", 32'(ready_read_o), 32'd0);

        // reset during WR_MEM after two acks
        req_i = 1'b1; rw_i = 1'b1; req_block_i = 1'b1; add_i = 24'h000300;
        step();
        req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            write_i = 1'b1; data_i = wd[i];
            step();
        end
        write_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ext_ack_i = 1'b1;
            step();
        end
        ext_ack_i = 1'b0;
        check_eq("rst5_pre_add", 32'(ext_add_o), 32'h302);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        check_eq("rst5_ext_req", 32'(ext_req_o), 32'd0);
        check_eq("rst5_block", 32'(ext_block_o), 32'd0);
        check_eq("rst5_ready_req_low", 32'(ready_req_o), 32'd0);
        step();
        check_eq("rst5_ready_req", 32'(ready_req_o), 32'd1);
        req_i = 1'b1; req_block_i = 1'b0; rw_i = 1'b1; add_i = 24'h000456;
        step();
        req_i = 1'b0;
        write_i = 1'b1; data_i = 32'h5555_AAAA;
        step();
        write_i = 1'b0;
        check_eq("rst5_new_req", 32'(ext_req_o), 32'd1);
        check_eq("rst5_new_add", 32'(ext_add_o), 32'h456);
        check_eq("rst5_new_data", ext_data_o, 32'h5555_AAAA);
        ext_ack_i = 1'b1;
        step();
        ext_ack_i = 1'b0;
        check_eq("rst5_new_done", 32'(ready_req_o), 32'd1);

        // req_i held high across a transfer
        req_i = 1'b1; req_block_i = 1'b0; rw_i = 1'b1; add_i = 24'h000010;
        step();
        rw_i = 1'b0; add_i = 24'h000020;
        check_eq("hold_ready_req_low", 32'(ready_req_o), 32'd0);
        write_i = 1'b1; data_i = 32'hE0E0_E0E0;
        step();
        write_i = 1'b0;
        check_eq("hold_wr_add", 32'(ext_add_o), 32'h10);
        check_eq("hold_wr_rw", 32'(ext_rw_o), 32'd1);
        ext_ack_i = 1'b1;
        step();
        ext_ack_i = 1'b0;
        check_eq("hold_idle_ready", 32'(ready_req_o), 32'd1);
        step();
        req_i = 1'b0;
        check_eq("hold_second_req", 32'(ext_req_o), 32'd1);
        check_eq("hold_second_rw", 32'(ext_rw_o), 32'd0);
        check_eq("hold_second_add", 32'(ext_add_o), 32'h20);
        ext_ack_i = 1'b1;
        step();
        ext_ack_i = 1'b0;
        ext_valid_i = 1'b1; ext_data_i = 32'hF00D_F00D;
        step();
        ext_valid_i = 1'b0;
        check_eq("hold_rd_data", data_o, 32'hF00D_F00D);
        read_i = 1'b1;
        step();
        read_i = 1'b0;
        check_eq("hold_rd_done", 32'(ready_req_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
